// File: rtl/dmem_pkg.sv
// Shared constants and types for the dmem_unit data memory slice.
// The optional DMEM_MISALIGN_SPLIT_EN build adds the SPLIT state behaviour.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_FUNCT3   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        SPLIT = 2'd3
    } state_t;

    // Access width in bytes; 0 marks a funct3 with no defined size.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: access_size = 3'd1;
            F3_H, F3_HU: access_size = 3'd2;
            F3_W:        access_size = 3'd4;
            default:     access_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Lane aligner over a little-endian 64-bit word pair: extends load data and
// produces the byte enables and positioned data for stores.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [63:0] pair,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  be,
    output logic [63:0] wpair
);

    logic [31:0] shifted;
    logic [3:0]  lanes;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        shifted = 32'(pair >> {offset, 3'b000});
        rdata   = '0;
        lanes   = '0;
        case (funct3)
            F3_B: begin
                rdata = {{24{shifted[7]}}, shifted[7:0]};
                lanes = 4'b0001;
            end
            F3_BU: begin
                rdata = {24'b0, shifted[7:0]};
                lanes = 4'b0001;
            end
            F3_H: begin
                rdata = {{16{shifted[15]}}, shifted[15:0]};
                lanes = 4'b0011;
            end
            F3_HU: begin
                rdata = {16'b0, shifted[15:0]};
                lanes = 4'b0011;
            end
            F3_W: begin
                rdata = shifted;
                lanes = 4'b1111;
            end
            default: ;
        endcase
        be    = {4'b0000, lanes} << offset;
        wpair = {32'b0, wdata} << {offset, 3'b000};
    end

endmodule

// File: rtl/dmem_unit.sv
// Single-outstanding RV32 load/store unit over a byte-enabled word RAM.
// Define DMEM_MISALIGN_SPLIT_EN to perform misaligned accesses instead of faulting.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES  = 16384,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_err_code
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IW    = $clog2(WORDS);
    localparam int CW    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    state_t      state;
    logic [CW-1:0] wait_cnt;
    logic        q_we;
    logic [2:0]  q_f3;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;

    logic [31:0] mem [WORDS];

    // While idle the live request is decoded; afterwards the latched copy is.
    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    assign sel_we    = (state == IDLE) ? req_we     : q_we;
    assign sel_f3    = (state == IDLE) ? req_funct3 : q_f3;
    assign sel_addr  = (state == IDLE) ? req_addr   : q_addr;
    assign sel_wdata = (state == IDLE) ? req_wdata  : q_wdata;

    logic [IW-1:0] idx;
    logic [IW-1:0] idx_hi;
    logic [31:0]   ld_data;
    logic [7:0]    st_be;
    logic [63:0]   st_pair;

    assign idx    = sel_addr[IW+1:2];
    assign idx_hi = idx + IW'(1);

    dmem_load_align u_align (
        .pair   ({mem[idx_hi], mem[idx]}),
        .offset (sel_addr[1:0]),
        .funct3 (sel_f3),
        .wdata  (sel_wdata),
        .rdata  (ld_data),
        .be     (st_be),
        .wpair  (st_pair)
    );

    logic [2:0]  size;
    logic [32:0] last_byte;
    logic        f3_bad;
    logic        range_bad;
    logic [1:0]  code;
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic        crosses;
`else
    logic        misaligned;
`endif

    always_comb begin
        size      = access_size(sel_f3);
        last_byte = {1'b0, sel_addr} + {30'b0, size} - 33'd1;
        f3_bad    = sel_we ? (sel_f3 > F3_W) : (size == 3'd0);
        range_bad = last_byte >= 33'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_SPLIT_EN
        crosses   = ({1'b0, sel_addr[1:0]} + size) > 3'd4;
        if (f3_bad)         code = ERR_FUNCT3;
        else if (range_bad) code = ERR_RANGE;
        else                code = ERR_NONE;
`else
        misaligned = ((size == 3'd2) && sel_addr[0]) ||
                     ((size == 3'd4) && (sel_addr[1:0] != 2'b00));
        if (f3_bad)          code = ERR_FUNCT3;
        else if (range_bad)  code = ERR_RANGE;
        else if (misaligned) code = ERR_MISALIGN;
        else                 code = ERR_NONE;
`endif
    end

    logic        accept;
    logic        mem_we;
    logic        err_next;
    logic [31:0] rdata_next;

    assign accept     = req_valid && req_ready;
    assign err_next   = (code != ERR_NONE);
    assign rdata_next = (sel_we || err_next) ? 32'd0 : ld_data;

    // Single-word stores commit on the acceptance edge; word-crossing ones in SPLIT.
`ifdef DMEM_MISALIGN_SPLIT_EN
    assign mem_we = !rst && (((state == IDLE) && accept && req_we && !err_next && !crosses) ||
                             ((state == SPLIT) && q_we));
`else
    assign mem_we = !rst && (state == IDLE) && accept && req_we && !err_next;
`endif

    // NOTE: the RAM array has no reset; clearing it would defeat RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (st_be[k])   mem[idx][8*k +: 8]    <= st_pair[8*k +: 8];
                if (st_be[k+4]) mem[idx_hi][8*k +: 8] <= st_pair[32 + 8*k +: 8];
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_err_code <= ERR_NONE;
            q_we         <= 1'b0;
            q_f3         <= '0;
            q_addr       <= '0;
            q_wdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_we      <= req_we;
                        q_f3      <= req_funct3;
                        q_addr    <= req_addr;
                        q_wdata   <= req_wdata;
                        req_ready <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
                        if (!err_next && crosses) begin
                            state <= SPLIT;
                        end else
`endif
                        if (READ_LATENCY == 1) begin
                            state        <= RESP;
                            rsp_valid    <= 1'b1;
                            rsp_rdata    <= rdata_next;
                            rsp_err      <= err_next;
                            rsp_err_code <= code;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SPLIT: begin
                    if (READ_LATENCY == 1) begin
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= rdata_next;
                        rsp_err      <= err_next;
                        rsp_err_code <= code;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= rdata_next;
                        rsp_err      <= err_next;
                        rsp_err_code <= code;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state        <= IDLE;
                        req_ready    <= 1'b1;
                        rsp_valid    <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_err      <= 1'b0;
                        rsp_err_code <= ERR_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench: two dmem_unit instances (READ_LATENCY 1 and 3) share one
// request stream; results are compared to a byte-level model and a vector table.
module tb_dmem_unit;

    localparam int DEPTH = 256;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_MODE = 1'b1;
`else
    localparam bit SPLIT_MODE = 1'b0;
`endif

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        rr1, rv1, re1, rr3, rv3, re3;
    logic [31:0] rd1, rd3;
    logic [1:0]  rc1, rc3;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem_model [DEPTH];

    always #5 clk = ~clk;

    dmem_unit #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(re1), .rsp_err_code(rc1)
    );

    dmem_unit #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr3), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(re3), .rsp_err_code(rc3)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // Byte-level reference: size, priority of faults, little-endian bytes, extension.
    function automatic void model_access(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rd, output logic [1:0] code,
                                         output int extra);
        int size;
        logic [31:0] v;
        size = (f3 == LB || f3 == LBU) ? 1 : (f3 == LH || f3 == LHU) ? 2 : (f3 == LW) ? 4 : 0;
        rd = 0; code = 0; extra = 0; v = 0;
        if ((we && f3 > 3'd2) || (!we && size == 0)) code = 2'd3;
        else if (longint'(addr) + size - 1 >= DEPTH) code = 2'd2;
        else if (!SPLIT_MODE && (addr % size) != 0) code = 2'd1;
        else begin
            if (SPLIT_MODE && (addr % 4) + size > 4) extra = 1;
            if (we) begin
                for (int b = 0; b < size; b++) mem_model[addr + b] = wdata[8*b +: 8];
            end else begin
                for (int b = 0; b < size; b++) v[8*b +: 8] = mem_model[addr + b];
                if (f3 == LB)      rd = {{24{v[7]}}, v[7:0]};
                else if (f3 == LH) rd = {{16{v[15]}}, v[15:0]};
                else               rd = v;
            end
        end
    endfunction

    task automatic exec(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_d, input logic [1:0] exp_c, input int extra,
                        input int hold, input bit poke);
        logic [31:0] d1, d3;
        logic [1:0]  c1, c3;
        logic        e1, e3;
        int          l1, l3, n;
        bit          stable;
        d1 = 0; d3 = 0; c1 = 0; c3 = 0; e1 = 0; e3 = 0; l1 = 0; l3 = 0; stable = 1;
        @(negedge clk);
        n = 0;
        while (!(rr1 && rr3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, ":ready"}, 32'(rr1 && rr3), 32'd1);
        if (!(rr1 && rr3)) return;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (l1 != 0) stable &= (rv1 && rd1 == d1 && re1 == e1 && rc1 == c1);
            if (l1 == 0 && rv1) begin l1 = k; d1 = rd1; e1 = re1; c1 = rc1; end
            if (l3 == 0 && rv3) begin l3 = k; d3 = rd3; e3 = re3; c3 = rc3; end
            if (l1 != 0 && l3 != 0) break;
            @(negedge clk);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            stable &= (rv1 && rv3 && rd1 == d1 && rd3 == d3 && !rr1 && !rr3);
            if (poke && h == 1) begin
                req_valid = 1'b1; req_we = 1'b1; req_funct3 = LW;
                req_addr = 32'h30; req_wdata = 32'hFFFF_FFFF;
            end
            if (h == 3) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, ":stable"}, 32'(stable), 32'd1);
        check({name, ":drop"}, {30'b0, rv1, rv3}, 32'd0);
        check({name, ":rdata1"}, d1, exp_d);
        check({name, ":rdata3"}, d3, exp_d);
        check({name, ":code1"}, 32'(c1), 32'(exp_c));
        check({name, ":code3"}, 32'(c3), 32'(exp_c));
        check({name, ":err1"}, 32'(e1), 32'(exp_c != 2'd0));
        check({name, ":err3"}, 32'(e3), 32'(exp_c != 2'd0));
        check({name, ":lat1"}, 32'(l1), 32'(1 + extra));
        check({name, ":lat3"}, 32'(l3), 32'(3 + extra));
    endtask

    // Model-predicted transaction.
    task automatic mtx(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] ed;
        logic [1:0]  ec;
        int          ex;
        model_access(we, f3, addr, wdata, ed, ec, ex);
        exec(name, we, f3, addr, wdata, ed, ec, ex, 0, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        logic [1:0]  exp_c;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ed, w, a;
        logic [1:0]  ec;
        logic [2:0]  f3;
        logic        we;
        int          ex;
        bit          quiet;

        rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0;
        repeat (2) @(negedge clk);
        check("reset:req_ready", {30'b0, rr1, rr3}, 32'd0);
        check("reset:rsp_valid", {30'b0, rv1, rv3}, 32'd0);
        check("reset:rdata", rd1 | rd3, 32'd0);
        check("reset:err", {28'b0, re1, re3, rc1 | rc3}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset:ready_after", {30'b0, rr1, rr3}, 32'd3);

        for (int i = 0; i < DEPTH / 4; i++) mtx("preload", 1'b1, LW, 32'(i * 4), $urandom());

        vecs.push_back('{"sw_10",       1'b1, LW,   32'h10, 32'hDEADBEEF, 32'h0,        2'd0});
        vecs.push_back('{"lw_10",       1'b0, LW,   32'h10, 32'h0,        32'hDEADBEEF, 2'd0});
        vecs.push_back('{"lb_13",       1'b0, LB,   32'h13, 32'h0,        32'hFFFFFFDE, 2'd0});
        vecs.push_back('{"lbu_13",      1'b0, LBU,  32'h13, 32'h0,        32'h000000DE, 2'd0});
        vecs.push_back('{"lh_12",       1'b0, LH,   32'h12, 32'h0,        32'hFFFFDEAD, 2'd0});
        vecs.push_back('{"lhu_12",      1'b0, LHU,  32'h12, 32'h0,        32'h0000DEAD, 2'd0});
        vecs.push_back('{"lb_10",       1'b0, LB,   32'h10, 32'h0,        32'hFFFFFFEF, 2'd0});
        vecs.push_back('{"lhu_10",      1'b0, LHU,  32'h10, 32'h0,        32'h0000BEEF, 2'd0});
        vecs.push_back('{"lw_top_m2",   1'b0, LW,   32'(DEPTH - 2), 32'h0, 32'h0,       2'd2});
        vecs.push_back('{"sb_depth",    1'b1, LB,   32'(DEPTH), 32'h77,   32'h0,        2'd2});
        vecs.push_back('{"lh_top_odd",  1'b0, LH,   32'(DEPTH - 1), 32'h0, 32'h0,       2'd2});
        vecs.push_back('{"ld_f3_3",     1'b0, 3'd3, 32'h10, 32'h0,        32'h0,        2'd3});
        vecs.push_back('{"st_f3_4",     1'b1, 3'd4, 32'h10, 32'h12345678, 32'h0,        2'd3});
        vecs.push_back('{"st_f3_7_oor", 1'b1, 3'd7, 32'(DEPTH), 32'h0,    32'h0,        2'd3});
        vecs.push_back('{"lw_10_again", 1'b0, LW,   32'h10, 32'h0,        32'hDEADBEEF, 2'd0});
        vecs.push_back('{"sb_50",       1'b1, LB,   32'h50, 32'hABCDEF11, 32'h0,        2'd0});
        vecs.push_back('{"sb_51",       1'b1, LB,   32'h51, 32'h99999922, 32'h0,        2'd0});
        vecs.push_back('{"sb_52",       1'b1, LB,   32'h52, 32'h12345633, 32'h0,        2'd0});
        vecs.push_back('{"sb_53",       1'b1, LB,   32'h53, 32'hFFFFFF44, 32'h0,        2'd0});
        vecs.push_back('{"lw_50",       1'b0, LW,   32'h50, 32'h0,        32'h44332211, 2'd0});
        vecs.push_back('{"sh_52",       1'b1, LH,   32'h52, 32'hAAAA5566, 32'h0,        2'd0});
        vecs.push_back('{"lw_50_sh",    1'b0, LW,   32'h50, 32'h0,        32'h55662211, 2'd0});
        vecs.push_back('{"sw_top",      1'b1, LW,   32'(DEPTH - 4), 32'hCAFEF00D, 32'h0, 2'd0});
        vecs.push_back('{"lw_top",      1'b0, LW,   32'(DEPTH - 4), 32'h0, 32'hCAFEF00D, 2'd0});
        vecs.push_back('{"lbu_top",     1'b0, LBU,  32'(DEPTH - 1), 32'h0, 32'h000000CA, 2'd0});

        foreach (vecs[i]) begin
            model_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, ed, ec, ex);
            exec(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_d, vecs[i].exp_c, 0, 0, 1'b0);
        end

        // Misaligned and word-crossing accesses.
        mtx("sw_20", 1'b1, LW, 32'h20, 32'h01020304);
        mtx("sw_24", 1'b1, LW, 32'h24, 32'h05060708);
        model_access(1'b1, LH, 32'h21, 32'h1234, ed, ec, ex);
        exec("sh_21", 1'b1, LH, 32'h21, 32'h1234, 32'h0, SPLIT_MODE ? 2'd0 : 2'd1, 0, 0, 1'b0);
        model_access(1'b0, LW, 32'h20, 0, ed, ec, ex);
        exec("lw_20_a", 1'b0, LW, 32'h20, 0, SPLIT_MODE ? 32'h01123404 : 32'h01020304, 2'd0, 0, 0, 1'b0);
        model_access(1'b1, LW, 32'h23, 32'hAABBCCDD, ed, ec, ex);
        exec("sw_23", 1'b1, LW, 32'h23, 32'hAABBCCDD, 32'h0, SPLIT_MODE ? 2'd0 : 2'd1,
             SPLIT_MODE ? 1 : 0, 0, 1'b0);
        model_access(1'b0, LW, 32'h20, 0, ed, ec, ex);
        exec("lw_20_b", 1'b0, LW, 32'h20, 0, SPLIT_MODE ? 32'hDD123404 : 32'h01020304, 2'd0, 0, 0, 1'b0);
        model_access(1'b0, LW, 32'h24, 0, ed, ec, ex);
        exec("lw_24", 1'b0, LW, 32'h24, 0, SPLIT_MODE ? 32'h05AABBCC : 32'h05060708, 2'd0, 0, 0, 1'b0);
        model_access(1'b0, LW, 32'h23, 0, ed, ec, ex);
        exec("lw_23", 1'b0, LW, 32'h23, 0, SPLIT_MODE ? 32'hAABBCCDD : 32'h0, SPLIT_MODE ? 2'd0 : 2'd1,
             SPLIT_MODE ? 1 : 0, 0, 1'b0);

        // Back-pressure: response held 5 cycles while a store is offered and must be ignored.
        mtx("sw_30", 1'b1, LW, 32'h30, 32'h0BADF00D);
        model_access(1'b0, LW, 32'h30, 0, ed, ec, ex);
        exec("hold_lw_30", 1'b0, LW, 32'h30, 0, 32'h0BADF00D, 2'd0, 0, 5, 1'b1);
        model_access(1'b0, LW, 32'h30, 0, ed, ec, ex);
        exec("lw_30_after_poke", 1'b0, LW, 32'h30, 0, 32'h0BADF00D, 2'd0, 0, 0, 1'b0);

        // Reset one cycle after accepting a store; a request offered during reset is dropped.
        @(negedge clk);
        check("rst_seq:ready", {30'b0, rr1, rr3}, 32'd3);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = LW; req_addr = 32'h40; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req_funct3 = LB; req_wdata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            quiet &= !rv1 && !rv3;
            @(negedge clk);
        end
        check("rst_seq:no_rsp", 32'(quiet), 32'd1);
        check("rst_seq:ready_after", {30'b0, rr1, rr3}, 32'd3);
        model_access(1'b1, LW, 32'h40, 32'h55, ed, ec, ex);
        model_access(1'b0, LW, 32'h40, 0, ed, ec, ex);
        exec("rst_seq:lw_40", 1'b0, LW, 32'h40, 0, 32'h00000055, 2'd0, 0, 0, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 9) > 7 ? 2 : $urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = 32'($urandom_range(0, DEPTH - 1));
                1: a = 32'(DEPTH - 6 + $urandom_range(0, 9));
                2: a = 32'($urandom_range(0, DEPTH / 4 - 1)) << 2;
                default: a = $urandom();
            endcase
            w = $urandom();
            mtx("rnd", we, f3, a, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
